// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LC-3b IF stage: PC, I-memory read sequencing, IF/ID register with one-entry hold buffer
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imem_address,
    output logic        imem_read,
    input  logic [15:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_id_valid,
    output logic [15:0] if_id_instruction,
    output logic [15:0] if_id_pc
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] drain_address;
    logic [15:0] buf_instruction;
    logic [15:0] buf_pc;
    logic [15:0] pc_plus2;
    logic        done;
    logic        redirect_lsb_unused;

    assign pc_plus2            = pc + 16'd2;
    assign done                = imem_read & imem_resp;
    assign redirect_lsb_unused = redirect_pc[0];

    // While draining, the memory still owns the old request, so its address must not move.
    assign imem_address = (state == DRAIN) ? drain_address : pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= FETCH;
            pc                <= RESET_PC;
            drain_address     <= 16'h0000;
            buf_instruction   <= 16'h0000;
            buf_pc            <= 16'h0000;
            imem_read         <= 1'b0;
            if_id_valid       <= 1'b0;
            if_id_instruction <= 16'h0000;
            if_id_pc          <= 16'h0000;
        end else if (redirect) begin
            pc              <= {redirect_pc[15:1], 1'b0};
            if_id_valid     <= 1'b0;
            buf_instruction <= 16'h0000;
            buf_pc          <= 16'h0000;
            imem_read       <= 1'b1;
            case (state)
                FETCH: begin
                    if (imem_read && !imem_resp) begin
                        state         <= DRAIN;
                        drain_address <= pc;
                    end else begin
                        state <= FETCH;
                    end
                end
                DRAIN:   state <= imem_resp ? FETCH : DRAIN;
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    imem_read <= 1'b1;
                    if (done) begin
                        if (!stall) begin
                            if_id_valid       <= 1'b1;
                            if_id_instruction <= imem_rdata;
                            if_id_pc          <= pc_plus2;
                            pc                <= pc_plus2;
                        end else begin
                            buf_instruction <= imem_rdata;
                            buf_pc          <= pc_plus2;
                            state           <= HOLD;
                            imem_read       <= 1'b0;
                        end
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_valid       <= 1'b1;
                        if_id_instruction <= buf_instruction;
                        if_id_pc          <= buf_pc;
                        pc                <= pc_plus2;
                        state             <= FETCH;
                        imem_read         <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (imem_resp) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state     <= FETCH;
                    imem_read <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized scoreboard bench for fetch_stage with a variable-latency I-memory
module tb_fetch_stage;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] imem_address;
    logic        imem_read;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        if_id_valid;
    logic [15:0] if_id_instruction;
    logic [15:0] if_id_pc;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_address     (imem_address),
        .imem_read        (imem_read),
        .imem_rdata       (imem_rdata),
        .imem_resp        (imem_resp),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .if_id_valid      (if_id_valid),
        .if_id_instruction(if_id_instruction),
        .if_id_pc         (if_id_pc)
    );

    always #5 clk = ~clk;

    // Memory model: each request completes after lat_cur cycles; pending requests cleared on reset.
    logic [15:0] mem [0:32767];
    int cnt = 0;
    int lat_cur = 1;
    int lat_lo = 1;
    int lat_hi = 1;

    assign imem_resp  = imem_read && (cnt >= lat_cur - 1);
    assign imem_rdata = imem_resp ? mem[imem_address[15:1]] : 16'hDEAD;

    always @(posedge clk) begin
        if (reset || !imem_read || imem_resp) begin
            cnt     <= 0;
            lat_cur <= int'($urandom_range(lat_hi, lat_lo));
        end else begin
            cnt <= cnt + 1;
        end
    end

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] push_pc = RESET_PC;
    int          total = 0;
    int          bad = 0;
    int          consumed = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Expected program order: sequential words from the last reset/redirect target.
    task automatic topup();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.instr = mem[push_pc[15:1]];
            e.pc    = push_pc + 16'd2;
            exp_q.push_back(e);
            push_pc = push_pc + 16'd2;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        topup();
    endtask

    task automatic set_redirect(input logic [15:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        exp_q.delete();
        push_pc = target & 16'hFFFE;
        topup();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        exp_q.delete();
        push_pc = RESET_PC;
        step();
        step();
        chk("rst_read", {15'b0, imem_read}, 16'h0000);
        chk("rst_valid", {15'b0, if_id_valid}, 16'h0000);
        chk("rst_instr", if_id_instruction, 16'h0000);
        chk("rst_pc", if_id_pc, 16'h0000);
        chk("rst_addr", imem_address, RESET_PC);
        reset = 1'b0;
    endtask

    // Monitor: decode consumes IF/ID when valid, not stalled and not being flushed.
    logic        prev_pending = 1'b0;
    logic        prev_redirect = 1'b0;
    logic [15:0] prev_addr = 16'h0000;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (prev_pending) begin
                chk("req_held_read", {15'b0, imem_read}, 16'h0001);
                chk("req_held_addr", imem_address, prev_addr);
            end
            if (prev_redirect) chk("no_valid_after_redirect", {15'b0, if_id_valid}, 16'h0000);
            if (if_id_valid && !stall && !redirect) begin
                consumed++;
                if (exp_q.size() == 0) begin
                    chk("sb_nonempty", 16'h0000, 16'h0001);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_instr", if_id_instruction, e.instr);
                    chk("sb_pc", if_id_pc, e.pc);
                end
            end
        end
        prev_pending  = !reset && imem_read && !imem_resp;
        prev_redirect = !reset && redirect;
        prev_addr     = imem_address;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] old_addr;
        int k;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1021;
        mem[1] = 16'h5260;

        // Zero-wait back-to-back fetch.
        lat_lo = 1; lat_hi = 1;
        step();
        do_reset();
        chk("t1_idle_read", {15'b0, imem_read}, 16'h0000);
        step();
        chk("t1_read", {15'b0, imem_read}, 16'h0001);
        chk("t1_addr0", imem_address, 16'h0000);
        chk("t1_resp", {15'b0, imem_resp}, 16'h0001);
        step();
        chk("t1_valid0", {15'b0, if_id_valid}, 16'h0001);
        chk("t1_instr0", if_id_instruction, 16'h1021);
        chk("t1_pc0", if_id_pc, 16'h0002);
        chk("t1_addr2", imem_address, 16'h0002);
        step();
        chk("t1_valid1", {15'b0, if_id_valid}, 16'h0001);
        chk("t1_instr1", if_id_instruction, 16'h5260);
        chk("t1_pc1", if_id_pc, 16'h0004);

        // Three-cycle memory latency.
        lat_lo = 3; lat_hi = 3;
        do_reset();
        step();
        chk("t2_resp_c1", {15'b0, imem_resp}, 16'h0000);
        step();
        chk("t2_resp_c2", {15'b0, imem_resp}, 16'h0000);
        chk("t2_valid_c2", {15'b0, if_id_valid}, 16'h0000);
        step();
        chk("t2_resp_c3", {15'b0, imem_resp}, 16'h0001);
        chk("t2_valid_c3", {15'b0, if_id_valid}, 16'h0000);
        chk("t2_addr_c3", imem_address, 16'h0000);
        step();
        chk("t2_valid_c4", {15'b0, if_id_valid}, 16'h0001);
        chk("t2_instr_c4", if_id_instruction, 16'h1021);
        chk("t2_addr_c4", imem_address, 16'h0002);

        // Stall in a response cycle for four cycles, then release.
        lat_lo = 1; lat_hi = 1;
        for (k = 0; k < 10 && !imem_resp; k++) step();
        step();
        step();
        chk("t3_read_before", {15'b0, imem_read}, 16'h0001);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_hold_read", {15'b0, imem_read}, 16'h0000);
            chk("t3_hold_valid", {15'b0, if_id_valid}, 16'h0001);
        end
        stall = 1'b0;
        step();
        chk("t3_release_read", {15'b0, imem_read}, 16'h0001);
        chk("t3_release_valid", {15'b0, if_id_valid}, 16'h0001);
        step();

        // Redirect while stalled in HOLD.
        stall = 1'b1;
        step();
        chk("t5_hold_read", {15'b0, imem_read}, 16'h0000);
        set_redirect(16'h0400);
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        chk("t5_valid", {15'b0, if_id_valid}, 16'h0000);
        chk("t5_addr", imem_address, 16'h0400);
        chk("t5_read", {15'b0, imem_read}, 16'h0001);
        step();
        step();

        // PC wrap at the top of memory; bit 0 of the target is ignored.
        set_redirect(16'hFFFF);
        step();
        redirect = 1'b0;
        chk("t6_addr_top", imem_address, 16'hFFFE);
        step();
        chk("t6_wrap_pc", if_id_pc, 16'h0000);
        chk("t6_wrap_addr", imem_address, 16'h0000);
        chk("t6_wrap_valid", {15'b0, if_id_valid}, 16'h0001);

        // Redirect with a read outstanding: drain at the old address, then fetch the target.
        lat_lo = 3; lat_hi = 3;
        for (k = 0; k < 20 && !(imem_read && !imem_resp); k++) step();
        chk("t4_found_pending", {15'b0, imem_read && !imem_resp}, 16'h0001);
        old_addr = imem_address;
        set_redirect(16'h3001);
        step();
        redirect = 1'b0;
        chk("t4_drain_addr", imem_address, old_addr);
        chk("t4_drain_valid", {15'b0, if_id_valid}, 16'h0000);
        for (k = 0; k < 10 && !imem_resp; k++) step();
        chk("t4_drain_resp", {15'b0, imem_resp}, 16'h0001);
        step();
        chk("t4_target_addr", imem_address, 16'h3000);
        chk("t4_target_read", {15'b0, imem_read}, 16'h0001);
        chk("t4_no_leak", {15'b0, if_id_valid}, 16'h0000);

        // Random stall/redirect/latency traffic with one mid-run reset.
        lat_lo = 1; lat_hi = 1;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (c == 2000) begin
                do_reset();
                continue;
            end
            if (c % 600 == 0) lat_hi = int'($urandom_range(4, 1));
            stall    = ($urandom % 4) == 0;
            redirect = 1'b0;
            if (($urandom % 25) == 0) set_redirect(16'($urandom));
        end
        stall    = 1'b0;
        redirect = 1'b0;
        step();
        step();
        chk("enough_consumed", {15'b0, consumed >= 1000}, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
